// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity checker.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PAR    = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam int unsigned FRAME_LEN_MAX = 255;

    // Bit counter must hold FRAME_LEN itself after the last data bit.
    function automatic int unsigned cnt_width(input int unsigned frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/parity_acc_cell.sv
// One-bit running XOR accumulator with synchronous clear and enable.
module parity_acc_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (clr) begin
            q <= 1'b0;
        end else if (en) begin
            q <= q ^ d;
        end
    end

endmodule

// File: rtl/serial_parity_checker.sv
// Bit-serial parity generator/checker with registered one-cycle frame report.
// Optional saturating error counter enabled by PARITY_ERRCNT_EN.
module serial_parity_checker
    import parity_pkg::*;
#(
    parameter int unsigned FRAME_LEN  = 8,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned ERR_CNT_W  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic din,
    input  logic din_valid,
    output logic ready,
    output logic busy,
    output logic calc_parity,
    output logic frame_done,
    output logic parity_err
`ifdef PARITY_ERRCNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    localparam int unsigned CNT_W = cnt_width(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic ODD_BIT = (PARITY_ODD != 0);

    if (FRAME_LEN < 1 || FRAME_LEN > FRAME_LEN_MAX || ERR_CNT_W < 1) begin : g_param_check
        $error("serial_parity_checker: parameter out of range");
    end

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept;
    logic             acc, acc_clr, acc_en;
    logic             ready_nxt, busy_nxt, done_nxt, calc_nxt, err_nxt;

    assign accept  = din_valid & ready;
    assign acc_clr = (state == IDLE) && start;
    assign acc_en  = (state == DATA) && accept;

    parity_acc_cell u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (acc_en),
        .d     (din),
        .q     (acc)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        calc_nxt  = calc_parity;
        err_nxt   = parity_err;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DATA;
                    cnt_nxt   = '0;
                end
            end
            DATA: begin
                if (accept) begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == LAST_IDX) begin
                        state_nxt = PAR;
                    end
                end
            end
            PAR: begin
                if (accept) begin
                    state_nxt = REPORT;
                    calc_nxt  = acc ^ ODD_BIT;
                    err_nxt   = din ^ acc ^ ODD_BIT;
                end
            end
            REPORT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Outputs are registered, so they are derived from the next state.
        ready_nxt = (state_nxt == DATA) || (state_nxt == PAR);
        busy_nxt  = (state_nxt != IDLE);
        done_nxt  = (state_nxt == REPORT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            calc_parity <= 1'b0;
            frame_done  <= 1'b0;
            parity_err  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ready       <= ready_nxt;
            busy        <= busy_nxt;
            calc_parity <= calc_nxt;
            frame_done  <= done_nxt;
            parity_err  <= err_nxt;
        end
    end

`ifdef PARITY_ERRCNT_EN
    // Counted on the same edge that raises frame_done with parity_err set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if ((state == PAR) && accept && err_nxt && (err_count != '1)) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// Self-checking bench: even and odd parity instances driven in parallel.
module tb_serial_parity_checker;

    localparam int FL      = 8;
    localparam int ERR_MAX = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic din = 1'b0;
    logic din_valid = 1'b0;

    logic ready_e, busy_e, calc_e, done_e, err_e;
    logic ready_o, busy_o, calc_o, done_o, err_o;
`ifdef PARITY_ERRCNT_EN
    logic [3:0] cnt_e, cnt_o;
`endif

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int model_errs_e = 0;
    int model_errs_o = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_parity_checker #(.FRAME_LEN(FL), .PARITY_ODD(0), .ERR_CNT_W(4)) u_even (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
        .ready(ready_e), .busy(busy_e), .calc_parity(calc_e), .frame_done(done_e),
        .parity_err(err_e)
`ifdef PARITY_ERRCNT_EN
        , .err_count(cnt_e)
`endif
    );

    serial_parity_checker #(.FRAME_LEN(FL), .PARITY_ODD(1), .ERR_CNT_W(4)) u_odd (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
        .ready(ready_o), .busy(busy_o), .calc_parity(calc_o), .frame_done(done_o),
        .parity_err(err_o)
`ifdef PARITY_ERRCNT_EN
        , .err_count(cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready_e"}, ready_e, 0);
        check({tag, "_busy_e"},  busy_e, 0);
        check({tag, "_calc_e"},  calc_e, 0);
        check({tag, "_done_e"},  done_e, 0);
        check({tag, "_err_e"},   err_e, 0);
        check({tag, "_ready_o"}, ready_o, 0);
        check({tag, "_busy_o"},  busy_o, 0);
        check({tag, "_calc_o"},  calc_o, 0);
        check({tag, "_done_o"},  done_o, 0);
        check({tag, "_err_o"},   err_o, 0);
`ifdef PARITY_ERRCNT_EN
        check({tag, "_cnt_e"}, cnt_e, 0);
        check({tag, "_cnt_o"}, cnt_o, 0);
`endif
    endtask

    // data[i] is the i-th bit on the wire; stall_len idle cycles follow bit stall_at.
    task automatic run_frame(input logic [FL-1:0] data, input logic pbit,
                             input int stall_at, input int stall_len, input bit poke_start);
        int  s;
        int  k;
        logic exp_e, exp_o;
        exp_e = ($countones(data) % 2) == 1;
        exp_o = !exp_e;

        @(negedge clk);
        start = 1'b1;
        din_valid = 1'b0;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy_e, 1);
        for (int i = 0; i < FL; i++) begin
            din_valid = 1'b1;
            din = data[i];
            if (poke_start && i == 3) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("ready_data", ready_e, 1);
            check("no_early_done", done_e, 0);
            if (i + 1 == stall_at) begin
                for (int j = 0; j < stall_len; j++) begin
                    din_valid = 1'b0;
                    din = 1'($urandom);
                    @(negedge clk);
                    check("ready_stall", ready_e, 1);
                    check("no_done_stall", done_e, 0);
                end
            end
        end
        din_valid = 1'b1;
        din = pbit;
        @(negedge clk);
        din_valid = 1'b0;
        din = 1'($urandom);
        k = 0;
        while (!done_e && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done_e, 1);
        check("done_latency", cyc - s, FL + 2 + stall_len);
        check("done_odd_inst", done_o, 1);
        check("calc_even", calc_e, exp_e);
        check("err_even", err_e, pbit != exp_e);
        check("calc_odd", calc_o, exp_o);
        check("err_odd", err_o, pbit != exp_o);
        if (pbit != exp_e && model_errs_e < ERR_MAX) model_errs_e++;
        if (pbit != exp_o && model_errs_o < ERR_MAX) model_errs_o++;

        if (poke_start) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", done_e, 0);
        check("busy_after_report", busy_e, 0);
        check("ready_after_report", ready_e, 0);
        check("calc_held", calc_e, exp_e);
        check("err_held", err_e, pbit != exp_e);
`ifdef PARITY_ERRCNT_EN
        check("errcnt_even", cnt_e, model_errs_e);
        check("errcnt_odd", cnt_o, model_errs_o);
`endif
        @(negedge clk);
        check("still_idle", busy_e, 0);
    endtask

    initial begin
        logic [FL-1:0] d;
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Even match / odd mismatch on the reference pattern 1,0,1,1,0,0,1,0.
        run_frame(8'h4D, 1'b0, -1, 0, 1'b0);
        // Same frame with a 3-cycle stall after bit 4.
        run_frame(8'h4D, 1'b0, 4, 3, 1'b0);
        // Start pulsed during DATA and REPORT.
        run_frame(8'h4D, 1'b0, -1, 0, 1'b1);

        // Reset after bit 5 of a frame.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din_valid = 1'b1;
            din = 1'($urandom);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1 check_all_zero("midreset");
        model_errs_e = 0;
        model_errs_o = 0;
        @(negedge clk);
        @(negedge clk);
        check("midreset_no_done", done_e, 0);
        din_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", busy_e, 0);
        check("post_reset_no_done", done_e, 0);
        run_frame(8'hFF, 1'b0, -1, 0, 1'b0);

        for (int n = 0; n < 12; n++) begin
            d = FL'($urandom);
            run_frame(d, 1'($urandom), int'($urandom_range(1, FL)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Consecutive even-parity mismatches drive the counter into saturation.
        for (int n = 0; n < 17; n++) begin
            d = FL'($urandom);
            run_frame(d, ($countones(d) % 2) == 0, -1, 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
- Bit-serial parity stage directly downstream of the two-input XOR cell.
- Folds each accepted data bit into a running XOR. After FRAME_LEN bits, compares the result against a trailing received parity bit.
- Reports the frame result as a one-cycle pulse.
- Used in the lab serial-link exercise as both parity generator (calc_parity) and parity checker (parity_err).

Parameters:
- FRAME_LEN, 8, data bits per frame (1..255).
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity. Expected parity bit = XOR(data) ^ PARITY_ODD.
- ERR_CNT_W, 4, width of the error counter (only used with the optional feature).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin frame; honoured only in IDLE.
- din  input  1  serial bit, data bits first, then the parity bit.
- din_valid  input  1  din qualifier; a bit is accepted when din_valid && ready.
- ready  output  1  high in DATA and PAR states.
- busy  output  1  high in any state other than IDLE.
- calc_parity  output  1  computed expected parity; valid while frame_done is high, held otherwise.
- frame_done  output  1  one-cycle pulse on frame completion.
- parity_err  output  1  valid with frame_done: 1 = received parity bit ≠ calc_parity.
- err_count  output  ERR_CNT_W  saturating error count (only with PARITY_ERRCNT_EN).

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; accumulator = 0; bit counter = 0.
  - ready = 0, busy = 0, calc_parity = 0, frame_done = 0, parity_err = 0, err_count = 0.
  - Applies immediately at any point, including mid-frame. The partial frame is discarded and no frame_done is produced.
- State machine (all outputs registered):
  - IDLE: start = 1 → DATA. Accumulator and counter are cleared on entry.
  - DATA: on each accepted bit, acc <= acc ^ din and cnt <= cnt + 1. When the accepted bit is number FRAME_LEN (cnt == FRAME_LEN-1 at acceptance) → PAR.
  - PAR: on the accepted bit → REPORT. Capture:
    - calc_parity <= acc ^ PARITY_ODD
    - parity_err <= din ^ acc ^ PARITY_ODD
  - REPORT: frame_done = 1 for exactly one cycle → IDLE.
- Latency: frame_done is asserted on the cycle after the parity bit is accepted.
- Minimum frame time: FRAME_LEN + 3 cycles, counted from the start cycle through the REPORT cycle.
- Stalls: din_valid = 0 in DATA or PAR holds all state. There is no timeout.
- start while busy (DATA, PAR or REPORT) is ignored with no side effect.
- start in the same cycle as REPORT is ignored. start must be presented again in IDLE.
- din/din_valid in IDLE or REPORT are ignored because ready = 0.
- Counter width: $clog2(FRAME_LEN+1) bits. It never wraps within a frame.
- parity_err is only meaningful while frame_done = 1. It holds its value otherwise.

Optional Feature:
- Macro: PARITY_ERRCNT_EN.
- Defined:
  - err_count increments on each frame_done with parity_err = 1.
  - It saturates at 2^ERR_CNT_W − 1 and does not wrap.
  - It is cleared only by reset.
- Undefined: the err_count port and its register are absent. All other behaviour is identical.

Decomposition:
- Package parity_pkg:
  - state enum {IDLE, DATA, PAR, REPORT} as a 2-bit typedef;
  - FRAME_LEN_MAX = 255;
  - helper constant for the counter width.
- One natural sub-module, parity_acc_cell:
  - 1-bit XOR accumulator flop with clear and enable, async active-low reset.
  - It wraps the XOR gate function and is instantiated once.

Test Plan:
- Even parity match: FRAME_LEN = 8, PARITY_ODD = 0, start, data 1,0,1,1,0,0,1,0 (four ones), parity bit 0 → frame_done pulse 10 cycles after the start cycle, calc_parity = 0, parity_err = 0.
- Odd parity mismatch: PARITY_ODD = 1, same data, parity bit 0 → calc_parity = 1, parity_err = 1; with macro defined, err_count 0 → 1.
- Stall: same frame as the first scenario with din_valid low for 3 cycles after bit 4 → identical result, frame_done delayed by exactly 3 cycles, ready stays high.
- Reset mid-frame: rst_n low after bit 5, released 2 cycles later → all outputs 0 immediately, no frame_done. A following full frame of eight 1s plus parity 0 → parity_err = 0.
- Start while busy: pulse start during DATA and again during REPORT → no restart, bit count unaffected, exactly one frame_done, busy = 0 the cycle after REPORT.
- Error saturation (macro defined, ERR_CNT_W = 4): 17 consecutive mismatched frames → err_count reaches 15 and stays at 15.
